// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory-port arbiter: FSM encoding, default bus widths
// and a helper for index widths.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 8;

  // Width of an index into n requesters; at least one bit even when n == 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after last, with wrap.
// Returns the winner both one-hot and as an index.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // cand[k] is the requester examined at priority position k.
  logic [IW-1:0] cand [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last) + gi + 1) % NREQ);
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && valid[cand[k]]) begin
        any            = 1'b1;
        grant[cand[k]] = 1'b1;
        idx            = cand[k];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between NREQ requesters, one transaction at a
// time, with a watchdog that aborts transactions memory never acknowledges.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             timeout_seen
);

  localparam int IW = idx_width(NREQ);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST   = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  logic [1:0]    state_reg;
  logic [IW-1:0] grant_reg;
  logic [IW-1:0] last_grant_reg;
  logic [WW-1:0] wdog_reg;
  logic          mem_req_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic [DW-1:0] rsp_rdata_reg;
  logic          rsp_err_reg;
  logic          timeout_seen_reg;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            abort;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (req_valid),
    .last  (last_grant_reg),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Abort lands on the TIMEOUT-th WAIT cycle without an ack; ack has priority.
  assign abort = (TIMEOUT != 0) && (wdog_reg == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= '0;
      last_grant_reg   <= LAST_INIT;
      wdog_reg         <= '0;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= '0;
      rsp_rdata_reg    <= '0;
      rsp_err_reg      <= 1'b0;
      timeout_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= req_we[pick_idx];
            mem_addr_reg  <= req_addr[pick_idx*AW +: AW];
            mem_wdata_reg <= req_wdata[pick_idx*DW +: DW];
            grant_reg     <= pick_idx;
            wdog_reg      <= '0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req_reg   <= 1'b0;
            rsp_rdata_reg <= mem_rdata;
            rsp_err_reg   <= 1'b0;
            state_reg     <= ST_DONE;
          end else if (abort) begin
            mem_req_reg      <= 1'b0;
            rsp_rdata_reg    <= {DW{1'b1}};
            rsp_err_reg      <= 1'b1;
            timeout_seen_reg <= 1'b1;
            state_reg        <= ST_DONE;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        ST_DONE: begin
          last_grant_reg <= grant_reg;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Held at zero during reset so no requester sees an accept while the port is down.
  assign req_ready = (rst_n && state_reg == ST_IDLE) ? pick_onehot : '0;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == ST_DONE) && (grant_reg == IW'(gi));
    end
  endgenerate

  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_err      = rsp_err_reg;
  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign timeout_seen = timeout_seen_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DW-1:0]    mem_rdata = '0;
  logic             busy;
  logic             timeout_seen;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin winner: first valid after last, wrapping; -1 when nobody asks.
  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Transaction-level model: one outstanding access, one response cycle.
  logic          m_active = 1'b0;
  logic          m_done   = 1'b0;
  int            m_owner  = 0;
  int            m_last   = NREQ - 1;
  int            m_waited = 0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] m_rdata  = '0;
  logic          m_err    = 1'b0;
  logic          m_tseen  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_owner <= 0; m_last <= NREQ - 1;
      m_waited <= 0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_err <= 1'b0; m_tseen <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_last <= m_owner;
    end else if (m_active) begin
      if (mem_ack) begin
        m_active <= 1'b0; m_done <= 1'b1; m_rdata <= mem_rdata; m_err <= 1'b0;
      end else if (TIMEOUT != 0 && m_waited + 1 == TIMEOUT) begin
        m_active <= 1'b0; m_done <= 1'b1; m_rdata <= 8'hFF; m_err <= 1'b1; m_tseen <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (pick(m_last, req_valid) >= 0) begin
      m_active <= 1'b1;
      m_waited <= 0;
      m_owner  <= pick(m_last, req_valid);
      m_we     <= req_we[pick(m_last, req_valid)];
      m_addr   <= req_addr[pick(m_last, req_valid)*AW +: AW];
      m_wdata  <= req_wdata[pick(m_last, req_valid)*DW +: DW];
    end
  end

  // Memory responder: acks on WAIT cycle index ack_after (-1 = never).
  int            ack_after = -1;
  logic [DW-1:0] rd_val = '0;
  logic          spurious = 1'b0;
  int            wcnt = 0;

  always @(negedge clk) begin
    if (spurious) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
    end else if (mem_req) begin
      mem_ack   = (ack_after >= 0 && wcnt == ack_after);
      mem_rdata = rd_val;
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Per-cycle comparison against the model, plus grant/response logging.
  int gq[$];
  int rq[$];
  logic [NREQ-1:0] exp_rdy;
  logic [NREQ-1:0] exp_rv;

  always @(negedge clk) begin
    #2;
    exp_rdy = '0;
    exp_rv  = '0;
    if (rst_n && !m_active && !m_done && pick(m_last, req_valid) >= 0)
      exp_rdy[pick(m_last, req_valid)] = 1'b1;
    if (m_done) exp_rv[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("mem_req", mem_req, m_active);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("rsp_err", rsp_err, m_err);
    chk("busy", busy, m_active | m_done);
    chk("timeout_seen", timeout_seen, m_tseen);
    if ((req_ready & req_valid) != 0) gq.push_back(req_ready[1] ? 1 : 0);
    if (rsp_valid != 0) begin
      rq.push_back(cyc);
      $display("txn cycle %0d: rsp_valid=%b rdata=%h err=%0d", cyc, rsp_valid, rsp_rdata, rsp_err);
    end
  end

  // Issue one request from the requesters in vmask and follow it to completion.
  task automatic do_txn(input logic [NREQ-1:0] vmask, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int aa, input logic [DW-1:0] rd,
                        output logic [NREQ-1:0] rdy, output int mreq_cyc,
                        output logic [NREQ-1:0] rv, output logic [DW-1:0] rdat,
                        output logic er, output int unstable);
    @(negedge clk);
    ack_after = aa;
    rd_val    = rd;
    for (int i = 0; i < NREQ; i++) begin
      if (vmask[i]) begin
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = wd;
      end
    end
    req_valid = vmask;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
    mreq_cyc = 0; rv = '0; rdat = '0; er = 1'b0; unstable = 0;
    for (int k = 0; k < 60; k++) begin
      #3;
      if (mem_req) begin
        mreq_cyc++;
        if (mem_we !== we || mem_addr !== a || mem_wdata !== wd) unstable++;
      end
      if (rsp_valid != 0) begin
        rv = rsp_valid; rdat = rsp_rdata; er = rsp_err;
        break;
      end
      @(negedge clk);
    end
    chk("txn_completed", (rv != 0), 1'b1);
  endtask

  logic [NREQ-1:0] t_rdy, t_rv;
  logic [DW-1:0]   t_rdat;
  logic            t_er;
  int              t_mreq, t_unst, quiet;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_timeout_seen", timeout_seen, 1'b0);
    rst_n = 1'b1;

    // Single read, zero-wait memory.
    do_txn(2'b01, 1'b0, 8'h12, 8'h00, 0, 8'hA5, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("read_ready", t_rdy, 2'b01);
    chk("read_mreq_cycles", t_mreq, 1);
    chk("read_rsp_valid", t_rv, 2'b01);
    chk("read_rdata", t_rdat, 8'hA5);
    chk("read_err", t_er, 1'b0);

    // Write from requester 1 with 3 wait states.
    do_txn(2'b10, 1'b1, 8'h40, 8'h3C, 3, 8'h11, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("write_ready", t_rdy, 2'b10);
    chk("write_mreq_cycles", t_mreq, 4);
    chk("write_hold_stable", t_unst, 0);
    chk("write_rsp_valid", t_rv, 2'b10);
    chk("write_rdata", t_rdat, 8'h11);

    // Contention: both valid for four transactions, zero-wait memory.
    @(negedge clk);
    gq.delete(); rq.delete();
    ack_after = 0; rd_val = 8'h5A;
    req_we = '0; req_addr = 16'h2120; req_wdata = 16'h0000;
    req_valid = 2'b11;
    repeat (11) @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rr_grant_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_grant_order", gq[i], i % 2);
    chk("rr_rsp_count", rq.size(), 4);
    for (int i = 1; i < 4 && i < rq.size(); i++) chk("rr_rsp_spacing", rq[i] - rq[i-1], 3);

    // Memory ignores us: watchdog aborts after 15 cycles.
    do_txn(2'b01, 1'b0, 8'h55, 8'h00, -1, 8'h00, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("timeout_mreq_cycles", t_mreq, 15);
    chk("timeout_rsp_valid", t_rv, 2'b01);
    chk("timeout_rdata", t_rdat, 8'hFF);
    chk("timeout_err", t_er, 1'b1);
    chk("timeout_seen_set", timeout_seen, 1'b1);

    // Next request is served normally; the sticky flag remains.
    do_txn(2'b10, 1'b0, 8'h66, 8'h00, 1, 8'h99, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("after_to_rsp_valid", t_rv, 2'b10);
    chk("after_to_mreq_cycles", t_mreq, 2);
    chk("after_to_rdata", t_rdat, 8'h99);
    chk("after_to_err", t_er, 1'b0);
    chk("timeout_seen_sticky", timeout_seen, 1'b1);

    // Ack while idle must be ignored.
    @(negedge clk);
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    spurious = 1'b0;
    #3 chk("spurious_ack_busy", busy, 1'b0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    ack_after = -1;
    req_addr[0 +: AW] = 8'h70;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #3 chk("pre_reset_mem_req", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_mem_req", mem_req, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_timeout_seen", timeout_seen, 1'b0);
    ack_after = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      #3 if (rsp_valid != 0) quiet++;
    end
    chk("no_rsp_after_reset", quiet, 0);

    // Both valid after reset: requester 0 wins first.
    do_txn(2'b11, 1'b0, 8'h31, 8'h00, 0, 8'hC3, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("post_reset_ready", t_rdy, 2'b01);
    chk("post_reset_rsp_valid", t_rv, 2'b01);

    // Ack on the 15th WAIT cycle coincides with the abort point; ack wins.
    do_txn(2'b10, 1'b0, 8'h44, 8'h00, 14, 8'h77, t_rdy, t_mreq, t_rv, t_rdat, t_er, t_unst);
    chk("coinc_mreq_cycles", t_mreq, 15);
    chk("coinc_rsp_valid", t_rv, 2'b10);
    chk("coinc_rdata", t_rdat, 8'h77);
    chk("coinc_err", t_er, 1'b0);
    chk("coinc_timeout_seen", timeout_seen, 1'b0);

    repeat (2) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single on-chip memory port of the CPU between NREQ requesters (CPU fetch/data, debug/serial loader).
- Accepts one request at a time, issues it to memory with a req/ack handshake, and returns the read data to the granted requester only.
- A watchdog aborts transactions that memory never acknowledges, so the core cannot hang and the LED/pins stay alive.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 8, address width
- DW, 8, data width
- TIMEOUT, 15, cycles in WAIT without mem_ack before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_we  in  NREQ  per-requester write enable
- req_addr  in  NREQ*AW  flat; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flat; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata  out  DW  read data, valid with rsp_valid
- rsp_err  out  1  completion was a timeout abort, valid with rsp_valid
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory done; sampled only while mem_req=1
- mem_rdata  in  DW  memory read data, valid with mem_ack
- busy  out  1  state != IDLE
- timeout_seen  out  1  sticky flag, set on any abort, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=NREQ-1, all outputs 0, watchdog=0. mem_req falls immediately, even mid-transaction. An in-flight transaction is dropped with no rsp_valid.
- States: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant]=1 combinationally; only in IDLE, at most one bit set.
  - Handshake completes on a clock edge with valid&ready. At that edge: latch we/addr/wdata into the mem_* registers, set mem_req=1, record grant, clear the watchdog, go to WAIT.
  - A requester may drop valid before it is granted; arbitration is re-evaluated every IDLE cycle.
- WAIT:
  - mem_* held stable.
  - mem_ack=1 at an edge: mem_req=0, rsp_rdata<=mem_rdata (written to mem_rdata value even for writes), rsp_err=0, go to DONE.
  - Else watchdog+1. When watchdog==TIMEOUT-1 and TIMEOUT!=0 (abort on the TIMEOUT-th cycle without ack): mem_req=0, rsp_rdata<={DW{1'b1}}, rsp_err=1, timeout_seen=1, go to DONE.
  - If mem_ack and the abort condition coincide, ack wins.
- DONE: rsp_valid[grant]=1 for exactly this cycle; last_grant<=grant; go to IDLE.
- rsp_rdata and rsp_err hold their value until the next completion.
- Latency:
  - Accept edge at end of cycle N; mem_req high in cycle N+1.
  - Zero-wait memory acks in N+1; rsp_valid in N+2; next accept possible in N+3.
  - Minimum 3 cycles per transaction. Each extra wait cycle adds 1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- mem_ack while mem_req=0 is ignored.
- Watchdog width: $clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_WAIT=1, ST_DONE=2)
  - the default AW/DW constants used by the CPU top
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs NREQ-bit valid and last_grant index; outputs one-hot grant and index.
- FSM, watchdog and mem registers stay in mem_port_arbiter.

Test Plan:
- Single read: req0 valid, addr=0x12, we=0; memory acks in 1st WAIT cycle with rdata=0xA5 -> req_ready[0] in cycle 0, mem_req cycles 1, rsp_valid=01 in cycle 2 with rdata=0xA5, rsp_err=0.
- Contention: req0 and req1 held valid for 4 transactions, zero-wait memory -> grant order 0,1,0,1; rsp_valid pulses every 3 cycles; never two req_ready bits set at once.
- Write with 3 wait states: req1 we=1, addr=0x40, wdata=0x3C -> mem_we=1, mem_addr=0x40, mem_wdata=0x3C stable 4 cycles; rsp_valid=10 one cycle after ack.
- Timeout: TIMEOUT=15, memory never acks -> mem_req high exactly 15 cycles; rsp_valid with rdata=0xFF, rsp_err=1; timeout_seen=1 and stays set; next request served normally.
- Ack/abort coincidence: ack arrives on the 15th WAIT cycle with rdata=0x77 -> rsp_rdata=0x77, rsp_err=0, timeout_seen stays 0.
- Reset mid-WAIT: rst_n low for 1 cycle while mem_req=1 -> mem_req 0 asynchronously, no rsp_valid; after release req0 with both valid is granted first (last_grant=NREQ-1).
